// File: rtl/bin_to_bcd_display_pkg.sv
// Shared types and constants for the binary-to-BCD display block:
// FSM state encoding, seven-segment glyphs and counter sizing.
package bin_to_bcd_display_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StDone = 2'd2
    } state_e;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegA     = 7'b0001000;
    localparam logic [6:0] SegB     = 7'b0000011;
    localparam logic [6:0] SegC     = 7'b1000110;
    localparam logic [6:0] SegD     = 7'b0100001;
    localparam logic [6:0] SegE     = 7'b0000110;
    localparam logic [6:0] SegF     = 7'b0001110;

    function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = Seg0;
            4'h1: seg = Seg1;
            4'h2: seg = Seg2;
            4'h3: seg = Seg3;
            4'h4: seg = Seg4;
            4'h5: seg = Seg5;
            4'h6: seg = Seg6;
            4'h7: seg = Seg7;
            4'h8: seg = Seg8;
            4'h9: seg = Seg9;
            4'hA: seg = SegA;
            4'hB: seg = SegB;
            4'hC: seg = SegC;
            4'hD: seg = SegD;
            4'hE: seg = SegE;
            default: seg = SegF;
        endcase
        return seg;
    endfunction

    // Counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bin_to_bcd_display_seg7_encoder.sv
// One seven-segment digit: hex glyph for a nibble, or all segments off when blanked.
module seg7_encoder
    import bin_to_bcd_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = blank_i ? SegBlank : seg_glyph(nibble_i);
    end

endmodule

// File: rtl/bin_to_bcd_display.sv
// Latches a value on start, converts it to BCD one bit per cycle (shift-add-3),
// and drives decimal or hex digits onto active-low seven-segment outputs.
module bin_to_bcd_display
    import bin_to_bcd_display_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned BLANK_ZEROS = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  overload,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   segments
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam int unsigned BcdW = 4 * DIGITS;

    state_e            state_q;
    logic [WIDTH-1:0]  shreg_q;
    logic [WIDTH-1:0]  value_q;
    logic              mode_q;
    logic [BcdW-1:0]   acc_q;
    logic              sticky_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [BcdW-1:0]   bcd_q;

    logic [BcdW-1:0]   acc_adj;
    logic [BcdW-1:0]   acc_shift;
    logic [WIDTH-1:0]  shreg_shift;
    logic              carry_out;
    logic [BcdW-1:0]   hex_bcd;
    logic              hex_ovf;
    logic [DIGITS-1:0] blank;

    // One double-dabble step: correct every nibble, then shift the joint register.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i+:4] >= 4'd5) begin
                acc_adj[4*i+:4] = acc_q[4*i+:4] + 4'd3;
            end
        end
        carry_out   = acc_adj[BcdW-1];
        acc_shift   = {acc_adj[BcdW-2:0], shreg_q[WIDTH-1]};
        shreg_shift = {shreg_q[WIDTH-2:0], 1'b0};
    end

    if (WIDTH > BcdW) begin : g_hex_wide
        assign hex_bcd = value_q[BcdW-1:0];
        assign hex_ovf = |value_q[WIDTH-1:BcdW];
    end else if (WIDTH == BcdW) begin : g_hex_exact
        assign hex_bcd = value_q;
        assign hex_ovf = 1'b0;
    end else begin : g_hex_narrow
        assign hex_bcd = {{(BcdW - WIDTH){1'b0}}, value_q};
        assign hex_ovf = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            value_q  <= '0;
            mode_q   <= 1'b0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            bcd_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        shreg_q  <= value;
                        value_q  <= value;
                        mode_q   <= mode;
                        acc_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= CntW'(WIDTH);
                        state_q  <= StConv;
                    end
                end
                StConv: begin
                    busy_q   <= 1'b1;
                    acc_q    <= acc_shift;
                    shreg_q  <= shreg_shift;
                    sticky_q <= sticky_q | carry_out;
                    cnt_q    <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    bcd_q   <= mode_q ? acc_q : hex_bcd;
                    ovf_q   <= mode_q ? sticky_q : hex_ovf;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Digit k>0 blanks when it and every higher digit are zero.
    always_comb begin : blank_calc
        logic nz;
        nz    = 1'b0;
        blank = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            nz       = nz | (bcd_q[4*k+:4] != 4'd0);
            blank[k] = (BLANK_ZEROS != 0) && (k != 0) && !nz;
        end
    end

    for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
        seg7_encoder u_enc (
            .nibble_i (bcd_q[4*k+:4]),
            .blank_i  (blank[k]),
            .seg_o    (segments[7*k+:7])
        );
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overload = ovf_q;
    assign bcd      = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus directed cases.
module tb_bin_to_bcd_display;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset   = 1'b0;
    logic        start8  = 1'b0;
    logic        mode8   = 1'b0;
    logic [7:0]  value8  = '0;
    logic        start12 = 1'b0;
    logic        mode12  = 1'b0;
    logic [11:0] value12 = '0;

    logic        busy8, done8, ovf8;
    logic [7:0]  bcd8;
    logic [13:0] seg8;
    logic        busyb, doneb, ovfb;
    logic [7:0]  bcdb;
    logic [13:0] segb;
    logic        busy12, done12, ovf12;
    logic [15:0] bcd12;
    logic [27:0] seg12;

    bin_to_bcd_display #(.WIDTH(8), .DIGITS(2), .BLANK_ZEROS(1)) dut (
        .clock(clock), .reset(reset), .start(start8), .mode(mode8), .value(value8),
        .busy(busy8), .done(done8), .overload(ovf8), .bcd(bcd8), .segments(seg8)
    );

    bin_to_bcd_display #(.WIDTH(8), .DIGITS(2), .BLANK_ZEROS(0)) dut_nb (
        .clock(clock), .reset(reset), .start(start8), .mode(mode8), .value(value8),
        .busy(busyb), .done(doneb), .overload(ovfb), .bcd(bcdb), .segments(segb)
    );

    bin_to_bcd_display #(.WIDTH(12), .DIGITS(4), .BLANK_ZEROS(1)) dut_w (
        .clock(clock), .reset(reset), .start(start12), .mode(mode12), .value(value12),
        .busy(busy12), .done(done12), .overload(ovf12), .bcd(bcd12), .segments(seg12)
    );

    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
        7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Result of a finished conversion, from plain arithmetic.
    function automatic void exp_result(input int width, input int digits, input logic m,
                                       input longint v, output logic [31:0] b,
                                       output logic o);
        longint lim;
        longint r;
        b = '0;
        if (m) begin
            lim = 1;
            for (int d = 0; d < digits; d++) lim = lim * 10;
            o = (v >= lim);
            r = v % lim;
            for (int d = 0; d < digits; d++) begin
                b[4*d+:4] = 4'(r % 10);
                r = r / 10;
            end
        end else begin
            lim = longint'(1) << (4 * digits);
            o = (v >= lim);
            b = 32'(v % lim);
        end
        if (width < 1) o = 1'bx;
    endfunction

    function automatic logic [27:0] exp_segs(input int digits, input bit blank,
                                             input logic [31:0] b);
        logic [27:0] s;
        logic [31:0] hi;
        s = '0;
        for (int k = 0; k < digits; k++) begin
            hi = b >> (4 * k);
            if (blank && k > 0 && hi == 0) s[7*k+:7] = 7'h7F;
            else s[7*k+:7] = GLYPH[b[4*k+:4]];
        end
        return s;
    endfunction

    // Cycle-level model: t counts edges since start was accepted (-1 = idle).
    int          m_t    [2] = '{-1, -1};
    logic        m_busy [2] = '{1'b0, 1'b0};
    logic        m_done [2] = '{1'b0, 1'b0};
    logic        m_ovf  [2] = '{1'b0, 1'b0};
    logic [31:0] m_bcd  [2] = '{32'd0, 32'd0};
    longint      m_lv   [2];
    logic        m_lm   [2];

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            logic   st, md;
            longint vv;
            int     w, dg;
            st = (i == 0) ? start8 : start12;
            md = (i == 0) ? mode8 : mode12;
            vv = (i == 0) ? longint'(value8) : longint'(value12);
            w  = (i == 0) ? 8 : 12;
            dg = (i == 0) ? 2 : 4;
            if (!reset) begin
                m_t[i] = -1; m_busy[i] = 1'b0; m_done[i] = 1'b0;
                m_ovf[i] = 1'b0; m_bcd[i] = '0;
            end else if (m_t[i] < 0) begin
                m_busy[i] = 1'b0; m_done[i] = 1'b0;
                if (st) begin m_t[i] = 0; m_lv[i] = vv; m_lm[i] = md; end
            end else begin
                m_t[i]++;
                m_busy[i] = (m_t[i] <= w);
                m_done[i] = (m_t[i] == w + 1);
                if (m_done[i]) begin
                    exp_result(w, dg, m_lm[i], m_lv[i], m_bcd[i], m_ovf[i]);
                    m_t[i] = -1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy8", busy8, m_busy[0]);
            check("done8", done8, m_done[0]);
            check("ovf8", ovf8, m_ovf[0]);
            check("bcd8", bcd8, m_bcd[0]);
            check("seg8", seg8, exp_segs(2, 1, m_bcd[0]));
            check("doneb", doneb, m_done[0]);
            check("ovfb", ovfb, m_ovf[0]);
            check("segb", segb, exp_segs(2, 0, m_bcd[0]));
            check("busy12", busy12, m_busy[1]);
            check("done12", done12, m_done[1]);
            check("ovf12", ovf12, m_ovf[1]);
            check("bcd12", bcd12, m_bcd[1]);
            check("seg12", seg12, exp_segs(4, 1, m_bcd[1]));
        end
    end

    task automatic conv8(input logic m, input logic [7:0] v, input int junk_at,
                         output int busy_cnt);
        bit seen;
        seen = 1'b0;
        busy_cnt = 0;
        @(negedge clock);
        start8 = 1'b1; mode8 = m; value8 = v;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clock);
            start8 = (c + 1 == junk_at);
            mode8  = ~m;
            value8 = v ^ 8'h5A;
            if (busy8) busy_cnt++;
            if (done8) seen = 1'b1;
        end
        check("conv8_done_seen", seen, 1);
    endtask

    task automatic conv12(input logic m, input logic [11:0] v);
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        start12 = 1'b1; mode12 = m; value12 = v;
        @(negedge clock);
        start12 = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (done12) seen = 1'b1;
            else @(negedge clock);
        end
        check("conv12_done_seen", seen, 1);
    endtask

    initial begin
        logic [31:0] pb;
        logic        po;
        int          bc;
        int          nd;

        // Pin the model against hand-computed values.
        exp_result(8, 2, 1'b1, 42, pb, po);    check("model_2A", {pb, 31'd0, po}, {32'h42, 32'd0});
        exp_result(8, 2, 1'b1, 255, pb, po);   check("model_FF", {pb, 31'd0, po}, {32'h55, 32'd1});
        exp_result(8, 2, 1'b0, 60, pb, po);    check("model_3C", {pb, 31'd0, po}, {32'h3C, 32'd0});
        exp_result(12, 4, 1'b1, 4095, pb, po); check("model_4095", {pb, 31'd0, po}, {32'h4095, 32'd0});
        check("model_seg_7b", exp_segs(2, 1, 32'h07), {7'h7F, 7'h78});
        check("model_seg_7n", exp_segs(2, 0, 32'h07), {7'h40, 7'h78});

        repeat (3) @(negedge clock);
        chk_en = 1'b1;
        check("rst_seg8", seg8, {7'h7F, 7'h40});
        check("rst_segb", segb, {7'h40, 7'h40});
        check("rst_bcd8", bcd8, 8'h00);
        reset = 1'b1;

        conv8(1'b1, 8'h2A, 0, bc);
        check("t1_busy_cycles", bc, 8);
        check("t1_bcd", bcd8, 8'h42);
        check("t1_ovf", ovf8, 1'b0);
        check("t1_seg", seg8, {7'h19, 7'h24});

        conv8(1'b1, 8'hFF, 0, bc);
        check("t2_bcd", bcd8, 8'h55);
        check("t2_ovf", ovf8, 1'b1);
        @(negedge clock);
        check("t2_done_once", done8, 1'b0);

        conv8(1'b0, 8'h3C, 0, bc);
        check("t3_busy_cycles", bc, 8);
        check("t3_bcd", bcd8, 8'h3C);
        check("t3_seg", seg8, {7'h30, 7'h46});

        conv8(1'b1, 8'd7, 0, bc);
        check("t4_seg_blank", seg8, {7'h7F, 7'h78});
        check("t4_seg_noblank", segb, {7'h40, 7'h78});

        conv8(1'b1, 8'd99, 3, bc);
        check("t5_bcd_ignored_start", bcd8, 8'h99);
        conv8(1'b1, 8'd100, 0, bc);
        check("t5_next_bcd", bcd8, 8'h00);
        check("t5_next_ovf", ovf8, 1'b1);
        check("t5_next_seg", seg8, {7'h7F, 7'h40});

        @(negedge clock);
        start8 = 1'b1; mode8 = 1'b1; value8 = 8'd200;
        @(negedge clock);
        start8 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("t6_busy", busy8, 1'b0);
        check("t6_bcd", bcd8, 8'h00);
        check("t6_ovf", ovf8, 1'b0);
        nd = 0;
        repeat (15) begin
            @(negedge clock);
            if (done8) nd++;
        end
        check("t6_no_done", nd, 0);

        conv12(1'b1, 12'd4095);
        check("t6w_bcd", bcd12, 16'h4095);
        check("t6w_ovf", ovf12, 1'b0);
        check("t6w_seg", seg12, {7'h19, 7'h40, 7'h10, 7'h12});
        conv12(1'b0, 12'hABC);
        check("hexw_bcd", bcd12, 16'h0ABC);
        check("hexw_seg", seg12, {7'h7F, 7'h08, 7'h03, 7'h46});

        for (int n = 0; n < 1500; n++) begin
            logic [7:0] picks [6];
            picks = '{8'd0, 8'd15, 8'd16, 8'd99, 8'd100, 8'd255};
            @(negedge clock);
            start8  = ($urandom_range(0, 3) == 0);
            mode8   = 1'($urandom);
            value8  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 5)] : 8'($urandom);
            start12 = ($urandom_range(0, 3) == 0);
            mode12  = 1'($urandom);
            value12 = 12'($urandom);
            reset   = ($urandom_range(0, 199) != 0);
        end
        @(negedge clock);
        reset = 1'b1; start8 = 1'b0; start12 = 1'b0;
        repeat (20) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
